// File: rtl/timer_pkg.sv
// Shared definitions for the timer debug step sequencer:
// state encodings and the default widths.
package timer_pkg;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HALT = 2'd1,
    ST_STEP = 2'd2
  } step_state_e;

  localparam int STEP_W_DEF = 8;
  localparam int TO_W_DEF   = 16;

endpackage

// File: rtl/timer_step_cnt.sv
// Loadable down-counter holding the remaining ticks of a debug step.
// Clear beats load beats decrement. The counter saturates at zero.
module timer_step_cnt
  import timer_pkg::*;
#(
  parameter int W = STEP_W_DEF
) (
  input  logic         sys_clk,
  input  logic         sys_rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  input  logic         clr,
  output logic [W-1:0] value,
  output logic         last
);

  logic [W-1:0] value_q, value_d;

  // next value: clear, load or saturating decrement
  always_comb begin
    value_d = value_q;
    if (clr)                        value_d = '0;
    else if (load)                  value_d = load_val;
    else if (dec && value_q != '0)  value_d = value_q - 1'b1;
  end

  // counter register
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) value_q <= '0;
    else            value_q <= value_d;
  end

  assign value = value_q;
  assign last  = (value_q == {{(W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/timer_step_seq.sv
// Debug halt / single-step sequencer for the timer counter path.
// Drives halt_req to the counter-enable generator and releases it for
// exactly step_cnt qualified ticks (cnt_en), then re-halts.
// Optional: define TIMER_STEP_TIMEOUT_EN to abandon a step (back to HALT)
// after 2^TO_W-1 consecutive cycles without a tick.
module timer_step_seq
  import timer_pkg::*;
#(
  parameter int STEP_W = STEP_W_DEF,
  parameter int TO_W   = TO_W_DEF
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              dbg_mode,
  input  logic              halt_cmd,
  input  logic              step_req,
  input  logic [STEP_W-1:0] step_cnt,
  input  logic              cnt_en,
  output logic              halt_req,
  output logic              halted,
  output logic              step_busy,
  output logic              step_done,
  output logic              step_abort,
  output logic [STEP_W-1:0] step_rem
);

  step_state_e state_q;
  logic        halt_req_q, busy_q, done_q, abort_q;
  logic        drop, in_step, last, complete, abort_drop, timeout, start, enter_halt;

  // Event decode. Completion wins over a dbg/halt drop, which wins over timeout.
  always_comb begin
    drop       = !dbg_mode || !halt_cmd;
    in_step    = (state_q == ST_STEP);
    complete   = in_step && cnt_en && last;
    abort_drop = in_step && !complete && drop;
    start      = (state_q == ST_HALT) && !drop && step_req && (step_cnt != '0);
    enter_halt = (state_q == ST_RUN) && halt_cmd && dbg_mode;
  end

`ifdef TIMER_STEP_TIMEOUT_EN
  logic [TO_W-1:0] idle_q;

  // idle cycles since STEP entry or the last tick; the step is abandoned
  // on the cycle the count would reach its maximum
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)              idle_q <= '0;
    else if (start || cnt_en)    idle_q <= '0;
    else if (in_step)            idle_q <= idle_q + 1'b1;
  end

  assign timeout = in_step && !cnt_en && !drop &&
                   (idle_q == {{(TO_W-1){1'b1}}, 1'b0});
`else
  assign timeout = 1'b0;
`endif

  timer_step_cnt #(.W(STEP_W)) u_cnt (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .load      (start),
    .load_val  (step_cnt),
    .dec       (in_step && cnt_en),
    .clr       (abort_drop || timeout),
    .value     (step_rem),
    .last      (last)
  );

  // sequencer FSM with registered outputs
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= ST_RUN;
      halt_req_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      done_q  <= complete;
      abort_q <= abort_drop || timeout;
      case (state_q)
        ST_RUN: if (enter_halt) begin
          state_q    <= ST_HALT;
          halt_req_q <= 1'b1;
        end
        ST_HALT: if (drop) begin
          state_q    <= ST_RUN;
          halt_req_q <= 1'b0;
        end else if (start) begin
          state_q    <= ST_STEP;
          halt_req_q <= 1'b0;
          busy_q     <= 1'b1;
        end
        ST_STEP: if (complete || timeout) begin
          state_q    <= ST_HALT;
          halt_req_q <= 1'b1;
          busy_q     <= 1'b0;
        end else if (abort_drop) begin
          state_q    <= ST_RUN;
          busy_q     <= 1'b0;
        end
        default: begin
          state_q    <= ST_RUN;
          halt_req_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign halt_req   = halt_req_q;
  assign halted     = (state_q == ST_HALT) && dbg_mode;
  assign step_busy  = busy_q;
  assign step_done  = done_q;
  assign step_abort = abort_q;

endmodule

// File: doc/timer_step_seq.md
# timer_step_seq

Debug halt/single-step sequencer for the timer counter path. Converts the register-level halt command and step requests into the `halt_req` level consumed by the counter-enable generator. Releases the halt for exactly N qualified count ticks, then re-halts, so a debugger can advance the timer deterministically. Sits between the register block and the counter-enable logic; it observes the final `cnt_en`.

## Interface
- `STEP_W`, 8: width of the step count and of the remaining-ticks register.
- `TO_W`, 16: width of the step-timeout counter; only used when the timeout feature is compiled in.

- `sys_clk`  in  1  clock
- `sys_rst_n`  in  1  asynchronous, active-low reset
- `dbg_mode`  in  1  debug mode enable from the register block
- `halt_cmd`  in  1  level halt command from the register block
- `step_req`  in  1  single-cycle step request pulse
- `step_cnt`  in  STEP_W  number of count ticks per step; sampled with `step_req`
- `cnt_en`  in  1  final count-enable pulse from the counter-enable generator
- `halt_req`  out  1  registered halt request to the counter-enable generator
- `halted`  out  1  high while in HALT and `dbg_mode`=1
- `step_busy`  out  1  high while in STEP
- `step_done`  out  1  one-cycle pulse when a step completes
- `step_abort`  out  1  one-cycle pulse when a step is abandoned
- `step_rem`  out  STEP_W  remaining ticks of the current step; 0 outside STEP

## Operation
- States: RUN (`halt_req`=0), HALT (`halt_req`=1), STEP (`halt_req`=0, counting).
- RUN: `halt_cmd && dbg_mode` → HALT. `step_req` is ignored.
- HALT transitions, in priority order:
  - `!dbg_mode || !halt_cmd` → RUN.
  - `step_req && step_cnt!=0` → STEP, loading `step_rem`=`step_cnt`.
  - `step_req && step_cnt==0` is ignored: no pulse, no state change.
- STEP transitions, in priority order:
  - `cnt_en && step_rem==1` → HALT, `step_done` pulse.
  - `!dbg_mode || !halt_cmd` → RUN, `step_abort` pulse, `step_rem` cleared.
  - `cnt_en` → `step_rem` decrements.
  - `step_req` during STEP is ignored; no re-arm, no queueing.
- A completing tick that coincides with a `dbg_mode`/`halt_cmd` drop reports `step_done`. The next cycle then exits HALT → RUN.
- Arithmetic: `step_rem` is an unsigned STEP_W down-counter and never wraps below 0. The maximum step is 2^STEP_W−1.

## Timing
- Reset values: state RUN, `halt_req`=0, `halted`=0, `step_busy`=0, `step_done`=0, `step_abort`=0, `step_rem`=0.
- Reset mid-STEP returns to RUN at once, with no `step_abort` pulse.
- All outputs are registered except `halted`, which is decoded from state and `dbg_mode`.
- Halt latency: `halt_cmd` sampled at edge k → `halt_req`=1 from k. The counter-enable generator gates `cnt_en` combinationally, so no `cnt_en` is seen after edge k.
- Step latency: `step_req` sampled at edge k → `halt_req`=0 and `step_busy`=1 from k.
- Step termination: the Nth `cnt_en` is sampled at edge m → from m, `halt_req`=1 and `step_busy`=0, and `step_done`=1 for one cycle.
- Exactly N `cnt_en` pulses occur while `halt_req`=0. This holds even with `cnt_en` high every cycle (divider off, N=1 gives exactly one tick).
- `cnt_en` stalls (timer disabled, divider slow) extend STEP indefinitely unless the timeout feature is compiled in.

## Configuration
- `TIMER_STEP_TIMEOUT_EN` defined:
  - A TO_W idle counter clears on entry to STEP and on every `cnt_en`, and increments otherwise.
  - On reaching 2^TO_W−1 in STEP: → HALT (not RUN), `step_abort` pulse, `step_rem` cleared.
  - Completion and the `dbg_mode`/`halt_cmd` drop both take priority over timeout.
- Not defined: no idle counter, STEP waits forever, and `TO_W` is unused.

## Structure
- `timer_pkg` holds:
  - the state encodings RUN=2'd0, HALT=2'd1, STEP=2'd2;
  - the default `STEP_W`/`TO_W` constants.
- One sub-module, `timer_step_cnt`: a loadable STEP_W down-counter with a load, decrement and clear interface and a `last` flag (`value==1`). The FSM stays in the top.

## Test plan
- Halt entry: `dbg_mode`=1, `halt_cmd` rises → `halt_req`=1 and `halted`=1 the next cycle, `cnt_en` quiet. Drop `halt_cmd` → RUN, `halt_req`=0.
- Step N=3 with `cnt_en` every cycle → exactly 3 `cnt_en` pulses, then `halt_req`=1, `step_done` for one cycle, `step_rem` sequence 3,2,1,0.
- Step with `cnt_en` every 4th cycle, N=2 → `step_busy` high for about 8 cycles, exactly 2 ticks counted, then `step_done`.
- Abort: `dbg_mode` drops with `step_rem`=5 → RUN, `step_abort` pulse, `step_rem`=0. The same drop on the final tick gives `step_done`, then RUN.
- Corner cases:
  - `step_cnt`=0 in HALT → no state change.
  - `step_req` in RUN or STEP → ignored.
  - Reset asserted mid-STEP → RUN with all outputs 0.
- With `TIMER_STEP_TIMEOUT_EN` and `TO_W`=4, step N=2 with `cnt_en` held 0 → after 15 cycles in STEP, HALT with a `step_abort` pulse.
